// File: rtl/pkg_8b10b.sv
// Shared 8b/10b receive definitions: sub-block decode tables, K-code and comma
// constants, and the symbol-lock state type used by decoder_10b8b.
package pkg_8b10b;

  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;
  localparam logic [9:0] K23_7_NEG = 10'b1110101000;
  localparam logic [9:0] K23_7_POS = 10'b0001010111;
  localparam logic [9:0] K27_7_NEG = 10'b1101101000;
  localparam logic [9:0] K27_7_POS = 10'b0010010111;
  localparam logic [9:0] K29_7_NEG = 10'b1011101000;
  localparam logic [9:0] K29_7_POS = 10'b0100010111;
  localparam logic [9:0] K30_7_NEG = 10'b0111101000;
  localparam logic [9:0] K30_7_POS = 10'b1000010111;

  localparam logic [5:0] K28_6B_NEG = 6'b001111;
  localparam logic [5:0] K28_6B_POS = 6'b110000;

  localparam logic [6:0] COMMA_NEG = 7'b0011111;
  localparam logic [6:0] COMMA_POS = 7'b1100000;

  typedef enum logic [1:0] {UNLOCKED, ACQUIRING, SYNCED} lock_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] data;
  } dec6_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] data;
  } dec4_t;

  // abcdei -> EDCBA; both disparity forms of every code map to the same value.
  function automatic dec6_t dec6(input logic [5:0] abcdei);
    dec6_t r;
    r.valid = 1'b1;
    r.data  = 5'd0;
    case (abcdei)
      6'b100111, 6'b011000: r.data = 5'd0;
      6'b011101, 6'b100010: r.data = 5'd1;
      6'b101101, 6'b010010: r.data = 5'd2;
      6'b110001:            r.data = 5'd3;
      6'b110101, 6'b001010: r.data = 5'd4;
      6'b101001:            r.data = 5'd5;
      6'b011001:            r.data = 5'd6;
      6'b111000, 6'b000111: r.data = 5'd7;
      6'b111001, 6'b000110: r.data = 5'd8;
      6'b100101:            r.data = 5'd9;
      6'b010101:            r.data = 5'd10;
      6'b110100:            r.data = 5'd11;
      6'b001101:            r.data = 5'd12;
      6'b101100:            r.data = 5'd13;
      6'b011100:            r.data = 5'd14;
      6'b010111, 6'b101000: r.data = 5'd15;
      6'b011011, 6'b100100: r.data = 5'd16;
      6'b100011:            r.data = 5'd17;
      6'b010011:            r.data = 5'd18;
      6'b110010:            r.data = 5'd19;
      6'b001011:            r.data = 5'd20;
      6'b101010:            r.data = 5'd21;
      6'b011010:            r.data = 5'd22;
      6'b111010, 6'b000101: r.data = 5'd23;
      6'b110011, 6'b001100: r.data = 5'd24;
      6'b100110:            r.data = 5'd25;
      6'b010110:            r.data = 5'd26;
      6'b110110, 6'b001001: r.data = 5'd27;
      6'b001110, 6'b001111, 6'b110000: r.data = 5'd28;
      6'b101110, 6'b010001: r.data = 5'd29;
      6'b011110, 6'b100001: r.data = 5'd30;
      6'b101011, 6'b010100: r.data = 5'd31;
      default:              r.valid = 1'b0;
    endcase
    return r;
  endfunction

  // fghj -> HGF; primary and alternate .7 forms both decode to 7.
  function automatic dec4_t dec4(input logic [3:0] fghj);
    dec4_t r;
    r.valid = 1'b1;
    r.data  = 3'd0;
    case (fghj)
      4'b1011, 4'b0100:                   r.data = 3'd0;
      4'b1001:                            r.data = 3'd1;
      4'b0101:                            r.data = 3'd2;
      4'b1100, 4'b0011:                   r.data = 3'd3;
      4'b1101, 4'b0010:                   r.data = 3'd4;
      4'b1010:                            r.data = 3'd5;
      4'b0110:                            r.data = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: r.data = 3'd7;
      default:                            r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_k_full(input logic [9:0] sym);
    return (sym == K23_7_NEG) || (sym == K23_7_POS) ||
           (sym == K27_7_NEG) || (sym == K27_7_POS) ||
           (sym == K29_7_NEG) || (sym == K29_7_POS) ||
           (sym == K30_7_NEG) || (sym == K30_7_POS);
  endfunction

  function automatic logic [2:0] ones6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/decoder_lock_fsm.sv
// Comma-based symbol-lock state machine; owns the lock state and all counters.
module decoder_lock_fsm
  import pkg_8b10b::*;
#(
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_LIMIT   = 4,
  parameter int GOOD_RUN    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sym_valid,
  input  logic comma,
  input  logic err,
  output logic synced
);

  localparam int CW = $clog2(LOCK_COMMAS) + 1;
  localparam int EW = $clog2(ERR_LIMIT) + 1;
  localparam int GW = $clog2(GOOD_RUN) + 1;
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_COMMAS);
  localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);
  localparam logic [GW-1:0] GOOD_MAX = GW'(GOOD_RUN);

  lock_state_e   state_q, state_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;

  always_comb begin
    // NOTE: every next-value gets a default first so no path can infer a latch.
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    if (sym_valid) begin
      case (state_q)
        UNLOCKED: begin
          if (comma && !err) begin
            state_d     = ACQUIRING;
            comma_cnt_d = CW'(1);
          end
        end
        ACQUIRING: begin
          if (err) begin
            state_d     = UNLOCKED;
            comma_cnt_d = '0;
          end else if (comma) begin
            comma_cnt_d = comma_cnt_q + CW'(1);
            if (comma_cnt_d == LOCK_MAX) begin
              state_d     = SYNCED;
              comma_cnt_d = '0;
              err_cnt_d   = '0;
              good_cnt_d  = '0;
            end
          end
        end
        SYNCED: begin
          if (err) begin
            good_cnt_d = '0;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + EW'(1);
            // Leaving lock clears the counters so the next acquisition starts clean.
            if (err_cnt_d == ERR_MAX) begin
              state_d   = UNLOCKED;
              err_cnt_d = '0;
            end
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
            if (good_cnt_d == GOOD_MAX) begin
              err_cnt_d  = '0;
              good_cnt_d = '0;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      good_cnt_q  <= '0;
      synced      <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      synced      <= (state_d == SYNCED);
    end
  end

endmodule

// File: rtl/decoder_10b8b.sv
// Receive-side 8b/10b decoder with running-disparity tracking and symbol lock.
// Define DECODER_DISP_CHECK_EN to enable disparity checking and rd tracking.
module decoder_10b8b
  import pkg_8b10b::*;
#(
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_LIMIT   = 4,
  parameter int GOOD_RUN    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] in_10b,
  input  logic       in_valid,
  output logic [7:0] out_8b,
  output logic       out_dataK,
  output logic       out_valid,
  output logic       code_err,
  output logic       disp_err,
  output logic       rd,
  output logic       synced
);

  logic [5:0] s6;
  logic [3:0] s4;
  dec6_t      d6;
  dec4_t      d4;
  logic       cerr, derr, is_k, comma, rd_next;
  logic [7:0] byte_d;

  always_comb begin
    s6 = in_10b[9:4];
    s4 = in_10b[3:0];
    d6 = dec6(s6);
    // The RD+ form of K28 carries the complemented 4b code.
    d4 = dec4((s6 == K28_6B_POS) ? ~s4 : s4);
    cerr   = !d6.valid || !d4.valid;
    byte_d = cerr ? 8'h00 : {d4.data, d6.data};
    is_k   = (s6 == K28_6B_NEG) || (s6 == K28_6B_POS) || is_k_full(in_10b);
    comma  = (in_10b[9:3] == COMMA_NEG) || (in_10b[9:3] == COMMA_POS);
  end

`ifdef DECODER_DISP_CHECK_EN
  logic       rd_mid;
  logic [2:0] n6, n4;

  always_comb begin
    derr    = 1'b0;
    rd_mid  = rd;
    rd_next = rd;
    n6 = ones6(s6);
    n4 = ones6({2'b00, s4});
    if (n6 > 3'd3 || s6 == 6'b111000) begin
      derr   = rd;
      rd_mid = 1'b1;
    end else if (n6 < 3'd3 || s6 == 6'b000111) begin
      derr   = !rd;
      rd_mid = 1'b0;
    end
    rd_next = rd_mid;
    if (n4 > 3'd2 || s4 == 4'b1100) begin
      if (rd_mid) derr = 1'b1;
      rd_next = 1'b1;
    end else if (n4 < 3'd2 || s4 == 4'b0011) begin
      if (!rd_mid) derr = 1'b1;
      rd_next = 1'b0;
    end
  end
`else
  always_comb begin
    derr    = 1'b0;
    rd_next = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_8b    <= 8'h00;
      out_dataK <= 1'b0;
      out_valid <= 1'b0;
      code_err  <= 1'b0;
      disp_err  <= 1'b0;
      rd        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_8b    <= byte_d;
        out_dataK <= is_k;
        code_err  <= cerr;
        disp_err  <= derr;
        rd        <= rd_next;
      end
    end
  end

  decoder_lock_fsm #(
    .LOCK_COMMAS(LOCK_COMMAS),
    .ERR_LIMIT  (ERR_LIMIT),
    .GOOD_RUN   (GOOD_RUN)
  ) u_lock (
    .clk      (clk),
    .reset    (reset),
    .sym_valid(in_valid),
    .comma    (comma),
    .err      (cerr | derr),
    .synced   (synced)
  );

endmodule
